// File: rtl/ram_crc_pkg.sv
// Shared types and CRC-4 constants for the CRC-protected register RAM.
// Polynomial x^4+x+1, zero seed, no final XOR.
package ram_crc_pkg;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  localparam int         CRC_W    = 4;
  localparam logic [3:0] CRC_POLY = 4'h3;
  localparam logic [3:0] CRC_INIT = 4'h0;

endpackage

// File: rtl/ram_crc_ctrl_crc4_gen.sv
// crc4_gen: combinational CRC-4 over a DATA_W word, MSB first.
// Latency: none (pure combinational). Backpressure: n/a.
module crc4_gen
  import ram_crc_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc
);

  always_comb begin
    logic [CRC_W-1:0] c;
    logic             fb;
    c  = CRC_INIT;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    crc = c;
  end

endmodule

// File: rtl/ram_crc_ctrl.sv
// ram_crc_ctrl: single-port register RAM with valid/ready access, init sweep, optional per-word CRC-4 (RAM_CRC_CHECK_EN).
// Latency: writes 0 cycles to visibility, reads 1 cycle to rsp_valid; init sweep takes DEPTH+1 edges.
// Backpressure: req_ready drops while a response is held by rsp_ready = 0, and throughout the init sweep.
module ram_crc_ctrl
  import ram_crc_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 3,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                err_inject,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [CRC_W-1:0]    rsp_crc,
  output logic                rsp_crc_err,
  output logic                init_done,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  logic [ADDR_W:0]   init_ptr;

  logic [DATA_W-1:0] mem_dat [DEPTH];

  logic              req_acc;
  logic              rd_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] rd_dat;
  logic [CRC_W-1:0]  wr_crc_calc;
  logic [CRC_W-1:0]  rd_crc_calc;
  logic [CRC_W-1:0]  rd_crc;
  logic              rd_err;

  assign req_ready = init_done & (~rsp_valid | rsp_ready);
  assign req_acc   = req_valid & req_ready;
  assign rd_acc    = req_acc & ~req_write;

  // The sweep borrows the write port; the pointer MSB marks "all words cleared".
  assign wr_en   = ((state == ST_INIT) && !init_ptr[ADDR_W]) || (req_acc && req_write);
  assign wr_addr = (state == ST_INIT) ? init_ptr[ADDR_W-1:0] : req_addr;
  assign wr_dat  = (state == ST_INIT) ? '0 : req_wdata;
  assign rd_dat  = mem_dat[req_addr];

  crc4_gen #(.DATA_W(DATA_W)) u_wr_crc (.data(wr_dat), .crc(wr_crc_calc));
  crc4_gen #(.DATA_W(DATA_W)) u_rd_crc (.data(rd_dat), .crc(rd_crc_calc));

`ifdef RAM_CRC_CHECK_EN
  logic [CRC_W-1:0] mem_crc [DEPTH];
  logic [CRC_W-1:0] wr_crc;

  assign wr_crc = wr_crc_calc ^ {{(CRC_W-1){1'b0}}, err_inject & (state == ST_IDLE)};
  assign rd_crc = mem_crc[req_addr];
  assign rd_err = (rd_crc_calc != rd_crc);

  always_ff @(posedge clk) begin
    if (wr_en) mem_crc[wr_addr] <= wr_crc;
  end
`else
  logic unused_crc;
  assign unused_crc = ^{err_inject, wr_crc_calc, rd_crc_calc};
  assign rd_crc     = '0;
  assign rd_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem_dat[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_ptr[ADDR_W]) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_crc     <= '0;
      rsp_crc_err <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (rd_acc) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= rd_dat;
        rsp_crc     <= rd_crc;
        rsp_crc_err <= rd_err;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rd_acc && rd_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_crc_ctrl.sv
// Bench for ram_crc_ctrl: directed scenarios then randomized traffic against a queue-free array model.
module tb_ram_crc_ctrl;

`ifdef RAM_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       err_inject = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_rdata;
  logic [3:0] rsp_crc;
  logic       rsp_crc_err;
  logic       init_done;
  logic [7:0] err_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ram_crc_ctrl #(.DATA_W(4), .ADDR_W(3), .ERRCNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .err_inject(err_inject),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_crc(rsp_crc), .rsp_crc_err(rsp_crc_err),
    .init_done(init_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // CRC as the remainder of data * x^4 divided by x^4 + x + 1 (0x13).
  function automatic logic [3:0] ref_crc(input logic [3:0] d);
    logic [7:0] r;
    r = {d, 4'h0};
    for (int b = 7; b >= 4; b--) if (r[b]) r = r ^ (8'h13 << (b - 4));
    return r[3:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick;
    chk_cnt++; if (req_ready !== 1'b0)   $display("FAIL rst_req_ready got=%b exp=0", req_ready);   else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0)   $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);   else pass_cnt++;
    chk_cnt++; if (rsp_rdata !== 4'h0)   $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata);   else pass_cnt++;
    chk_cnt++; if (rsp_crc !== 4'h0)     $display("FAIL rst_rsp_crc got=%h exp=0", rsp_crc);       else pass_cnt++;
    chk_cnt++; if (rsp_crc_err !== 1'b0) $display("FAIL rst_crc_err got=%b exp=0", rsp_crc_err);   else pass_cnt++;
    chk_cnt++; if (init_done !== 1'b0)   $display("FAIL rst_init_done got=%b exp=0", init_done);   else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'h00)    $display("FAIL rst_err_cnt got=%h exp=0", err_cnt);       else pass_cnt++;
  endtask

  task automatic test_init;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd0; rsp_ready = 1'b1;
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick;
      chk_cnt++;
      if (req_ready !== 1'b0 || init_done !== 1'b0)
        $display("FAIL init_hold edge=%0d got ready=%b done=%b exp 0/0", e, req_ready, init_done);
      else pass_cnt++;
    end
    tick;
    chk_cnt++; if (init_done !== 1'b1) $display("FAIL init_done_edge9 got=%b exp=1", init_done); else pass_cnt++;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL init_ready_edge9 got=%b exp=1", req_ready); else pass_cnt++;
    for (int a = 0; a < 8; a++) begin
      req_addr = 3'(a);
      tick;
      chk_cnt++;
      if ({rsp_valid, rsp_rdata, rsp_crc, rsp_crc_err} !== {1'b1, 4'h0, 4'h0, 1'b0})
        $display("FAIL init_read addr=%0d got v=%b d=%h c=%h e=%b exp 1/0/0/0",
                 a, rsp_valid, rsp_rdata, rsp_crc, rsp_crc_err);
      else pass_cnt++;
    end
    req_valid = 1'b0;
    tick;
  endtask

  task automatic test_write_read;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 4'hA; err_inject = 1'b0;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got=%b exp=0", rsp_valid); else pass_cnt++;
    req_write = 1'b0;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL wr_rd_valid got=%b exp=1", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_rdata !== 4'hA) $display("FAIL wr_rd_rdata got=%h exp=a", rsp_rdata); else pass_cnt++;
    chk_cnt++; if (rsp_crc !== (CRC_EN ? 4'hD : 4'h0)) $display("FAIL wr_rd_crc got=%h exp=%h", rsp_crc, CRC_EN ? 4'hD : 4'h0); else pass_cnt++;
    chk_cnt++; if (rsp_crc_err !== 1'b0) $display("FAIL wr_rd_err got=%b exp=0", rsp_crc_err); else pass_cnt++;
    req_valid = 1'b0;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL wr_rd_clear got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_err_inject;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_wdata = 4'h3; err_inject = 1'b1;
    tick;
    err_inject = 1'b0; req_write = 1'b0;
    tick;
    chk_cnt++; if (rsp_rdata !== 4'h3) $display("FAIL inj_rdata got=%h exp=3", rsp_rdata); else pass_cnt++;
    chk_cnt++; if (rsp_crc !== (CRC_EN ? 4'h4 : 4'h0)) $display("FAIL inj_crc got=%h exp=%h", rsp_crc, CRC_EN ? 4'h4 : 4'h0); else pass_cnt++;
    chk_cnt++; if (rsp_crc_err !== CRC_EN) $display("FAIL inj_err got=%b exp=%b", rsp_crc_err, CRC_EN); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'(CRC_EN ? 1 : 0)) $display("FAIL inj_cnt1 got=%0d exp=%0d", err_cnt, CRC_EN ? 1 : 0); else pass_cnt++;
    tick;
    chk_cnt++; if (err_cnt !== 8'(CRC_EN ? 2 : 0)) $display("FAIL inj_cnt2 got=%0d exp=%0d", err_cnt, CRC_EN ? 2 : 0); else pass_cnt++;
    req_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 4'hA) $display("FAIL stall_first got v=%b d=%h exp 1/a", rsp_valid, rsp_rdata); else pass_cnt++;
    req_addr = 3'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_cnt++; if (req_ready !== 1'b0) $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, req_ready); else pass_cnt++;
      tick;
      chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 4'hA) $display("FAIL stall_hold cyc=%0d got v=%b d=%h exp 1/a", c, rsp_valid, rsp_rdata); else pass_cnt++;
    end
    rsp_ready = 1'b1;
    #1;
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL release_ready got=%b exp=1", req_ready); else pass_cnt++;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h3) $display("FAIL b2b_rsp got v=%b d=%h exp 1/3", rsp_valid, rsp_rdata); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 8'(CRC_EN ? 3 : 0)) $display("FAIL b2b_cnt got=%0d exp=%0d", err_cnt, CRC_EN ? 3 : 0); else pass_cnt++;
    req_valid = 1'b0;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_clear got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5;
    tick;
    chk_cnt++; if (rsp_valid !== 1'b1) $display("FAIL rm_pending got=%b exp=1", rsp_valid); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_crc, rsp_crc_err, init_done, err_cnt} !== '0)
      $display("FAIL rm_async got rdy=%b v=%b d=%h c=%h e=%b done=%b cnt=%h exp all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_crc, rsp_crc_err, init_done, err_cnt);
    else pass_cnt++;
    tick; tick;
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick;
      chk_cnt++; if (rsp_valid !== 1'b0 || init_done !== 1'b0) $display("FAIL rm_sweep1 edge=%0d got v=%b done=%b exp 0/0", e, rsp_valid, init_done); else pass_cnt++;
    end
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if (init_done !== 1'b0 || req_ready !== 1'b0) $display("FAIL rm_init_rst got done=%b rdy=%b exp 0/0", init_done, req_ready); else pass_cnt++;
    tick;
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick;
      chk_cnt++; if (rsp_valid !== 1'b0 || init_done !== 1'b0) $display("FAIL rm_sweep2 edge=%0d got v=%b done=%b exp 0/0", e, rsp_valid, init_done); else pass_cnt++;
    end
    tick;
    chk_cnt++; if (init_done !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rm_done got done=%b v=%b exp 1/0", init_done, rsp_valid); else pass_cnt++;
    req_valid = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic test_random;
    logic [3:0] m_dat [8];
    logic [3:0] m_crc [8];
    logic       e_vld, e_err, e_rdy, acc;
    logic [3:0] e_rd, e_crc;
    logic [7:0] e_cnt;
    logic       v, w, inj, rr;
    logic [2:0] a;
    logic [3:0] d;
    for (int i = 0; i < 8; i++) begin m_dat[i] = 4'h0; m_crc[i] = 4'h0; end
    e_vld = 1'b0; e_err = 1'b0; e_rd = 4'h0; e_crc = 4'h0; e_cnt = 8'h0;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      w   = 1'($urandom_range(0, 1));
      a   = 3'($urandom_range(0, 7));
      d   = 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 4) == 0);
      rr  = ($urandom_range(0, 3) != 0);
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; err_inject = inj; rsp_ready = rr;
      e_rdy = !e_vld || rr;
      #1;
      chk_cnt++; if (req_ready !== e_rdy) $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, e_rdy); else pass_cnt++;
      acc = v && e_rdy;
      tick;
      if (acc && w) begin
        m_dat[a] = d;
        m_crc[a] = CRC_EN ? (ref_crc(d) ^ {3'b000, inj}) : 4'h0;
      end
      if (acc && !w) begin
        e_vld = 1'b1;
        e_rd  = m_dat[a];
        e_crc = CRC_EN ? m_crc[a] : 4'h0;
        e_err = CRC_EN && (ref_crc(m_dat[a]) != m_crc[a]);
        if (e_err && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
      end else if (rr) begin
        e_vld = 1'b0;
      end
      chk_cnt++; if (rsp_valid !== e_vld)   $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, rsp_valid, e_vld);   else pass_cnt++;
      chk_cnt++; if (rsp_rdata !== e_rd)    $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rsp_rdata, e_rd);    else pass_cnt++;
      chk_cnt++; if (rsp_crc !== e_crc)     $display("FAIL rnd_crc n=%0d got=%h exp=%h", n, rsp_crc, e_crc);       else pass_cnt++;
      chk_cnt++; if (rsp_crc_err !== e_err) $display("FAIL rnd_err n=%0d got=%b exp=%b", n, rsp_crc_err, e_err); else pass_cnt++;
      chk_cnt++; if (err_cnt !== e_cnt)     $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, err_cnt, e_cnt);     else pass_cnt++;
    end
    req_valid = 1'b0; err_inject = 1'b0; rsp_ready = 1'b1;
  endtask

  initial begin
    #1;
    test_reset;
    test_init;
    test_write_read;
    test_err_inject;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ram_crc_ctrl.md
# ram_crc_ctrl

Parametrised single-port register-array memory. It is the generational successor to the fixed 8x4 flip-flop RAM in the memory-access path. It adds a valid/ready request/response handshake, a registered read, and a post-reset initialisation sweep. Each word carries a CRC-4 that is stored on write and checked on read. It sits between the access controller and the storage array, and its error status feeds the system error monitor.

## Interface
- DATA_W, default 4: data word width in bits, 1..32.
- ADDR_W, default 3: address width; DEPTH = 2**ADDR_W words.
- ERRCNT_W, default 8: width of the saturating CRC-error counter.

- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: request can be accepted this cycle.
- req_write, input, 1: 1 = write, 0 = read.
- req_addr, input, ADDR_W: word address.
- req_wdata, input, DATA_W: write data.
- err_inject, input, 1: sampled with a write; the stored CRC has bit 0 inverted.
- rsp_valid, output, 1: read response present.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_rdata, output, DATA_W: read data.
- rsp_crc, output, 4: stored CRC of the word read.
- rsp_crc_err, output, 1: recomputed CRC differs from stored CRC.
- init_done, output, 1: initialisation sweep complete.
- err_cnt, output, ERRCNT_W: saturating count of responses with rsp_crc_err = 1.

## Operation
**CRC definition**
- Polynomial x^4+x+1 (0x3), initial value 0, no final XOR.
- Data is processed MSB first. Per bit: fb = crc[3]^bit, then crc = {crc[2:0],1'b0} ^ (fb ? 4'h3 : 4'h0).
- Example values: CRC(0x0) = 0x0, CRC(0xA) = 0xD.

**State machine: INIT → IDLE**
- INIT is entered on reset.
  - Writes word 0 with CRC 0 to addresses 0..DEPTH-1, one address per cycle, ascending.
  - Sweep pointer width is ADDR_W+1.
  - req_ready = 0 throughout INIT.
- INIT → IDLE on the cycle after address DEPTH-1 is written; init_done rises on that cycle.
- IDLE holds until reset.

**Handshake**
- req_ready = init_done & (~rsp_valid | rsp_ready).
- A request is accepted when req_valid & req_ready at a clock edge.

**Write**
- At the accepting edge, the array stores req_wdata.
- It also stores CRC(req_wdata) ^ {3'b0, err_inject}.
- No response is produced.

**Read**
- At the accepting edge, the response registers load:
  - rsp_rdata = array data.
  - rsp_crc = stored CRC.
  - rsp_crc_err = (CRC(data) != stored CRC).
  - rsp_valid is set.
- rsp_valid and all rsp_* fields hold stable until the rsp_ready handshake.
- rsp_valid clears on handshake unless a new read is accepted on the same edge.

**Error counter**
- err_cnt increments by 1 on each accepted read whose computed rsp_crc_err = 1.
- It saturates at all-ones.

**Boundary conditions**
- Read immediately following a write to the same address returns the new data. The array updates at the write edge, before the next read.
- All addresses 0..DEPTH-1 are valid, so there is no out-of-range case.
- reset asserted at any time:
  - Asynchronously clears rsp_valid, rsp_rdata, rsp_crc, rsp_crc_err, err_cnt and init_done, and returns the FSM to INIT.
  - A pending response is dropped.
  - Array contents are not reset directly; the INIT sweep rewrites them.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_crc = 0, rsp_crc_err = 0, init_done = 0, err_cnt = 0.
- init_done goes high DEPTH+1 rising edges after reset deasserts; this is 9 edges for ADDR_W = 3.
- Read latency is 1 cycle: rsp_valid is high in the cycle after the accepting edge.
- Throughput is one request per cycle while rsp_ready = 1.
- With rsp_ready = 0 and rsp_valid = 1, req_ready = 0 and requests stall.
- Write-to-read latency is 0: a read accepted one cycle after a write sees the written data.

## Configuration
- RAM_CRC_CHECK_EN defined: behaviour is as described above, with DATA_W+4 stored bits per word.
- RAM_CRC_CHECK_EN undefined:
  - No CRC storage; each word is DATA_W bits.
  - rsp_crc is tied to 0, rsp_crc_err is tied to 0, and err_cnt is held at 0.
  - err_inject is ignored.
  - Data path, handshake and INIT sweep are unchanged.

## Structure
- Package ram_crc_pkg contains:
  - the state enum (INIT, IDLE);
  - CRC_W = 4;
  - CRC_POLY = 4'h3;
  - CRC_INIT = 4'h0.
- Sub-module crc4_gen: combinational, parameter DATA_W, input data, output 4-bit CRC.
  - One instance is used on the write path (also used with zero data during INIT).
  - One instance is used on the read-check path.

## Test plan
- Release reset, hold req_valid = 1 → req_ready = 0 and init_done = 0 for 8 edges. init_done = 1 after edge 9. A read of each address 0..7 returns rdata = 0x0, crc = 0x0, err = 0.
- Write 0xA to address 5, then read address 5 on the next cycle → rsp_valid one cycle later, rdata = 0xA, rsp_crc = 0xD, rsp_crc_err = 0.
- Write 0x3 to address 2 with err_inject = 1, then read address 2 → rsp_crc_err = 1 and err_cnt = 1. A second read gives err_cnt = 2.
- Read address 5 with rsp_ready = 0 for 3 cycles → rsp_valid and rsp_rdata held stable, req_ready = 0. On rsp_ready = 1 with a new read of address 2 queued, a back-to-back response follows with no bubble.
- Assert reset during INIT (after 4 edges) and while a response is pending → outputs return to reset values immediately. The full 9-edge sweep restarts and the pending response is never presented.
- Build without RAM_CRC_CHECK_EN, repeat the err_inject write and read → rsp_crc_err = 0, err_cnt = 0, rdata correct.
